// File: rtl/sub_bytes_seq_if.sv
// Stream bundle for the iterative SubBytes stage: one input and one output valid/ready channel.
// A transfer on either channel happens at a rising edge where valid && ready; the producer keeps data stable until then.
interface sub_bytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out
    );

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out
    );
endinterface

// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes: LANES bytes per cycle through forward S-box ROMs, MS chunk first,
// with an IDLE/BUSY/DONE controller between a valid/ready input and a valid/ready output.
module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic              clk,
    input  logic              rst,
    sub_bytes_seq_if.slave    bus,
    output logic [1:0]        dbg_state
);
    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [127:0]  work;
    logic [127:0]  work_sub;
    logic [7:0]    lane_in  [LANES];
    logic [7:0]    lane_out [LANES];
    logic          last_chunk;

    assign last_chunk = (cnt == CW'(N - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_in[l]  = work[127 - 8 * (LANES * int'(cnt) + l) -: 8];
        assign lane_out[l] = SBOX[2047 - 8 * int'(lane_in[l]) -: 8];
    end

    always_comb begin
        work_sub = work;
        for (int l = 0; l < LANES; l++) begin
            work_sub[127 - 8 * (LANES * int'(cnt) + l) -: 8] = lane_out[l];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = BUSY;
            BUSY:    if (last_chunk) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work <= bus.state_in;
                        cnt  <= '0;
                    end
                end
                BUSY: begin
                    work <= work_sub;
                    cnt  <= last_chunk ? '0 : cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Both flags decode the state register only, so no ready/valid combinational loop can form.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.state_out = work;
    assign dbg_state     = state;
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: GF(2^8)-derived S-box model with a per-cycle scoreboard on the LANES=4
// instance, plus directed FIPS-197 vectors on LANES=4, 1 and 16.
module tb_sub_bytes_seq;
    logic clk;
    logic rst;
    logic [1:0] dbg4, dbg1, dbg16;

    sub_bytes_seq_if b4 ();
    sub_bytes_seq_if b1 ();
    sub_bytes_seq_if b16 ();

    sub_bytes_seq #(.LANES(4))  u4  (.clk(clk), .rst(rst), .bus(b4),  .dbg_state(dbg4));
    sub_bytes_seq #(.LANES(1))  u1  (.clk(clk), .rst(rst), .bus(b1),  .dbg_state(dbg1));
    sub_bytes_seq #(.LANES(16)) u16 (.clk(clk), .rst(rst), .bus(b16), .dbg_state(dbg16));

    localparam logic [127:0] C1_IN   = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] C1_OUT  = 128'h63cab7040953d051cd60e0e7ba70e18c;
    localparam logic [127:0] C1_SROW = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] B_IN    = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] B_OUT   = 128'hd42711aee0bf98f1b8b45de51e415230;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    bit chk_en   = 0;
    logic [7:0]   msb [256];
    logic [127:0] exp_q [$];

    // clock / reset
    initial clk = 0;
    always #5 clk = ~clk;

    // reference S-box from GF(2^8) inversion plus the affine map
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    initial begin
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gf_mul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
            msb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    function automatic logic [127:0] model_sub(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = msb[s[8*i +: 8]];
        return r;
    endfunction

    // FIPS byte 0 is the top byte; state[r][c] = byte r+4c
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                r[127 - 8*(rr + 4*c) -: 8] = s[127 - 8*(rr + 4*((c + rr) % 4)) -: 8];
        return r;
    endfunction

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard model for the LANES=4 instance
    function automatic bit model_out_valid(input int c);
        return (exp_q.size() > 0) && (c >= acc_cyc + 5);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (model_out_valid(cyc) && b4.out_ready) void'(exp_q.pop_front());
            else if (exp_q.size() == 0 && b4.in_valid) begin
                exp_q.push_back(model_sub(b4.state_in));
                acc_cyc = cyc;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_int("sb_in_ready", int'(b4.in_ready), int'(exp_q.size() == 0));
            check_int("sb_out_valid", int'(b4.out_valid), int'(model_out_valid(cyc)));
            if (model_out_valid(cyc)) check128("sb_state_out", b4.state_out, exp_q[0]);
        end
    end

    // driver tasks (called from the post-edge phase)
    task automatic send(input logic [127:0] d);
        int t;
        t = 0;
        b4.in_valid = 1'b1;
        b4.state_in = d;
        while (!b4.in_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (!b4.in_ready) check_int("send_timeout", t, 0);
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
    endtask

    task automatic recv(output logic [127:0] d, output int lat);
        lat = 0;
        while (!b4.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        d = b4.state_out;
        b4.out_ready = 1'b1;
        @(posedge clk); #1;
        b4.out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] r, d, r1, r16;
        logic [127:0] res [$];
        int lat, lat1, lat16, n_acc;
        int acc_t [2];
        bit will_acc;

        rst = 1'b1;
        b4.in_valid = 0;  b4.out_ready = 0;  b4.state_in = '0;
        b1.in_valid = 0;  b1.out_ready = 0;  b1.state_in = '0;
        b16.in_valid = 0; b16.out_ready = 0; b16.state_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // pin the model to published values
        check_int("model_sbox_00", int'(msb[8'h00]), 'h63);
        check_int("model_sbox_53", int'(msb[8'h53]), 'hed);
        check_int("model_sbox_ff", int'(msb[8'hff]), 'h16);
        check128("model_appb", model_sub(B_IN), B_OUT);
        check128("model_srow", shift_rows(C1_OUT), C1_SROW);

        // reset state
        check_int("rst_in_ready", int'(b4.in_ready), 1);
        check_int("rst_out_valid", int'(b4.out_valid), 0);
        check128("rst_state_out", b4.state_out, 128'h0);

        send(128'h0);
        recv(r, lat);
        check_int("zero_latency", lat, 4);
        check128("zero_result", r, {16{8'h63}});

        send(C1_IN);
        recv(r, lat);
        check128("c1_result", r, C1_OUT);
        check128("c1_shiftrows", shift_rows(r), C1_SROW);

        send(B_IN);
        recv(r, lat);
        check128("appb_l4", r, B_OUT);

        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            send(d);
            recv(r, lat);
            check128("rand_result", r, model_sub(d));
        end

        // LANES=1 and LANES=16 on App. B
        b1.in_valid = 1;  b1.state_in = B_IN;  b1.out_ready = 1;
        b16.in_valid = 1; b16.state_in = B_IN; b16.out_ready = 1;
        check_int("l1_in_ready", int'(b1.in_ready), 1);
        check_int("l16_in_ready", int'(b16.in_ready), 1);
        @(posedge clk); #1;
        b1.in_valid = 0; b16.in_valid = 0;
        lat1 = -1; lat16 = -1; r1 = '0; r16 = '0;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            if (b1.out_valid && lat1 < 0)   begin lat1 = t;  r1 = b1.state_out;   end
            if (b16.out_valid && lat16 < 0) begin lat16 = t; r16 = b16.state_out; end
        end
        check_int("l1_latency", lat1, 16);
        check_int("l16_latency", lat16, 1);
        check128("appb_l1", r1, B_OUT);
        check128("appb_l16", r16, B_OUT);

        // backpressure in DONE
        d = {4{32'h0a1b2c3d}};
        send(d);
        lat = 0;
        while (!b4.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        r = b4.state_out;
        check128("bp_result", r, model_sub(d));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_int("bp_out_valid", int'(b4.out_valid), 1);
            check_int("bp_in_ready", int'(b4.in_ready), 0);
            check128("bp_stable", b4.state_out, r);
        end
        b4.out_ready = 1;
        @(posedge clk); #1;
        b4.out_ready = 0;
        check_int("bp_release_valid", int'(b4.out_valid), 0);
        check_int("bp_release_ready", int'(b4.in_ready), 1);

        // reset two cycles after accept
        send(B_IN);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check_int("mrst_out_valid", int'(b4.out_valid), 0);
        check_int("mrst_in_ready", int'(b4.in_ready), 1);
        check128("mrst_state_out", b4.state_out, 128'h0);
        b4.out_ready = 1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (b4.out_valid) lat++;
        end
        b4.out_ready = 0;
        check_int("mrst_no_valid", lat, 0);

        // back-to-back with in_valid held high
        b4.out_ready = 1;
        b4.in_valid = 1;
        b4.state_in = {16{8'hff}};
        n_acc = 0;
        for (int t = 0; t < 30; t++) begin
            will_acc = b4.in_valid && b4.in_ready;
            @(posedge clk); #1;
            if (will_acc && n_acc < 2) begin
                acc_t[n_acc] = t;
                n_acc++;
                if (n_acc == 1) b4.state_in = {16{8'h53}};
                else b4.in_valid = 0;
            end
            if (b4.out_valid) res.push_back(b4.state_out);
        end
        b4.out_ready = 0;
        check_int("b2b_accepts", n_acc, 2);
        check_int("b2b_spacing", acc_t[1] - acc_t[0], 6);
        check_int("b2b_count", res.size(), 2);
        if (res.size() == 2) begin
            check128("b2b_first", res[0], {16{8'h16}});
            check128("b2b_second", res[1], {16{8'hed}});
        end

        repeat (2) @(posedge clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
